irq_latch8: RTL and testbench

- Interrupt request front-end for the 8-to-3 priority encoder; sits directly upstream of it.
- Synchronises eight asynchronous request lines and edge-detects them.
- Latches and masks the requests, then drives the 8-bit pending vector into the encoder's I input.
- Consumes the encoder's Y/Idle outputs to run a req/ack/eoi handshake with the CPU and clear serviced requests.

---
 rtl/irq_latch8_pkg.sv | 29 ++
 rtl/irq_latch8_if.sv | 29 ++
 rtl/irq_latch8_sync_edge.sv | 45 ++++
 rtl/irq_latch8.sv | 108 ++++++++++
 tb/tb_irq_latch8.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_latch8_pkg.sv
// Shared types and constants for the irq_latch8 interrupt front-end.
// Holds the FSM encoding, bus widths and the mask reset value.
`ifndef IRQ_LATCH8_PKG_SV
`define IRQ_LATCH8_PKG_SV

package irq_latch8_pkg;

  localparam int IRQ_N = 8;
  localparam int VEC_W = 3;

  localparam logic [IRQ_N-1:0] MASK_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SERV = 2'b10
  } state_t;

  // One-hot select of the request line addressed by a vector index.
  function automatic logic [IRQ_N-1:0] vec2bit(input logic [VEC_W-1:0] v);
    logic [IRQ_N-1:0] b;
    b    = '0;
    b[v] = 1'b1;
    return b;
  endfunction

endpackage

`endif

// File: rtl/irq_latch8_if.sv
// Bundles the request, mask, encoder and CPU handshake signals of irq_latch8.
// slave = the latch block itself; master = its surroundings (sources, encoder, CPU).
interface irq_latch8_if;
  import irq_latch8_pkg::*;

  logic [IRQ_N-1:0] irq_in;
  logic             mask_we;
  logic [IRQ_N-1:0] mask_wdata;
  logic [IRQ_N-1:0] mask_q;
  logic [IRQ_N-1:0] pend;
  logic [VEC_W-1:0] enc_y;
  logic             enc_idle;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack;
  logic             int_eoi;
  logic             int_busy;

  modport slave (
    input  irq_in, mask_we, mask_wdata, enc_y, enc_idle, int_ack, int_eoi,
    output mask_q, pend, int_req, int_vec, int_busy
  );

  modport master (
    output irq_in, mask_we, mask_wdata, enc_y, enc_idle, int_ack, int_eoi,
    input  mask_q, pend, int_req, int_vec, int_busy
  );

endinterface

// File: rtl/irq_latch8_sync_edge.sv
// One request line: SYNC_STAGES-flop synchroniser followed by a rise detector.
// With IRQ_LEVEL_TRIG_EN defined the history flop is dropped and o_set carries the synced level.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_set
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef IRQ_LEVEL_TRIG_EN
  assign o_set = w_synced;
`else
  logic r_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= w_synced;
    end
  end

  // A held level yields a single set pulse.
  assign o_set = w_synced & ~r_hist;
`endif

endmodule

// File: rtl/irq_latch8.sv
// Interrupt front-end: synchronise, latch and mask 8 requests for the priority encoder, then run req/ack/eoi with the CPU.
// IRQ_LEVEL_TRIG_EN selects level-triggered pending (no latching, ack does not clear).
module irq_latch8
  import irq_latch8_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  irq_latch8_if.slave bus
);

  logic [IRQ_N-1:0] w_set;
  logic [IRQ_N-1:0] r_pend_raw;
  logic [IRQ_N-1:0] r_mask;
  logic [VEC_W-1:0] r_vec;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_ack_ok;

  for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.irq_in[gi]),
      .o_set   (w_set[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask <= MASK_RST;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wdata;
    end
  end

`ifdef IRQ_LEVEL_TRIG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_raw <= '0;
    end else begin
      r_pend_raw <= w_set;
    end
  end
`else
  logic [IRQ_N-1:0] w_clr;

  assign w_clr = w_ack_ok ? vec2bit(r_vec) : '0;

  // Set is ORed after the clear so a same-cycle rise on the serviced bit survives the ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_raw <= '0;
    end else begin
      r_pend_raw <= (r_pend_raw & ~w_clr) | (w_set & ~r_mask);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_vec <= bus.enc_y;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ack_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.enc_idle) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.int_ack) begin
          w_ack_ok    = 1'b1;
          w_state_nxt = ST_SERV;
        end
      end
      ST_SERV: begin
        if (bus.int_eoi) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mask_q   = r_mask;
  assign bus.pend     = r_pend_raw & ~r_mask;
  assign bus.int_req  = (r_state == ST_REQ);
  assign bus.int_busy = (r_state == ST_SERV);
  assign bus.int_vec  = r_vec;

endmodule

// File: tb/tb_irq_latch8.sv
// Bench for irq_latch8 with a behavioural priority encoder closing the pend -> Y/Idle loop.
// Expected vectors are queued when requests are raised and popped when int_req is seen.
module tb_irq_latch8;
  import irq_latch8_pkg::*;

  logic clk;
  logic rst_n;

  irq_latch8_if bus ();

  irq_latch8 #(
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.enc_idle = (bus.pend == 8'h00);
    bus.enc_y    = 3'd0;
    for (int k = 0; k < IRQ_N; k++) begin
      if (bus.pend[k]) bus.enc_y = 3'(k);
    end
  end

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [VEC_W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input string tag);
    logic [VEC_W-1:0] exp_vec;
    int               cyc;
    cyc = 0;
    while (!bus.int_req && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bus.int_req) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      chk({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      exp_vec = sb_q.pop_front();
      chk({tag, "_vec"}, 32'(bus.int_vec), 32'(exp_vec));
    end
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.int_eoi = 1'b1;
    tick();
    bus.int_eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.irq_in     = 8'hFF;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 8'h00;
    bus.int_ack    = 1'b0;
    bus.int_eoi    = 1'b0;

    // Reset with all lines high
    tick(3);
    chk("rst_pend", 32'(bus.pend), 32'h00);
    chk("rst_req", 32'(bus.int_req), 32'd0);
    chk("rst_mask", 32'(bus.mask_q), 32'h00);
    chk("rst_busy", 32'(bus.int_busy), 32'd0);
    chk("rst_vec", 32'(bus.int_vec), 32'd0);
    bus.irq_in = 8'h00;
    tick();
    rst_n = 1'b1;
    tick(3);

    // Latency on bit 5
    bus.irq_in = 8'h20;
    tick();
    chk("lat_e1_pend", 32'(bus.pend), 32'h00);
    tick();
    chk("lat_e2_pend", 32'(bus.pend), 32'h00);
    tick();
    chk("lat_e3_pend", 32'(bus.pend), 32'h20);
    chk("lat_e3_req", 32'(bus.int_req), 32'd0);
    sb_q.push_back(3'd5);
    tick();
    chk("lat_e4_req", 32'(bus.int_req), 32'd1);
    wait_req("lat");
    pulse_ack();
    chk("lat_ack_pend", 32'(bus.pend), 32'h00);
    chk("lat_ack_busy", 32'(bus.int_busy), 32'd1);
    chk("lat_ack_req", 32'(bus.int_req), 32'd0);
    pulse_eoi();
    chk("lat_eoi_busy", 32'(bus.int_busy), 32'd0);
    tick(2);
    chk("lat_idle_req", 32'(bus.int_req), 32'd0);
    bus.irq_in = 8'h00;
    tick(4);

    // Priority and freeze
    bus.irq_in = 8'h44;
    sb_q.push_back(3'd6);
    wait_req("prio6");
    bus.irq_in = 8'hC4;
    tick(4);
    chk("freeze_vec", 32'(bus.int_vec), 32'd6);
    chk("freeze_pend", 32'(bus.pend), 32'hC4);
    sb_q.push_back(3'd7);
    sb_q.push_back(3'd2);
    pulse_ack();
    pulse_eoi();
    wait_req("prio7");
    pulse_ack();
    pulse_eoi();
    wait_req("prio2");
    pulse_ack();
    pulse_eoi();
    chk("prio_done_pend", 32'(bus.pend), 32'h00);
    bus.irq_in = 8'h00;
    tick(4);

    // Masked rise is discarded
    write_mask(8'h08);
    chk("mask_q08", 32'(bus.mask_q), 32'h08);
    bus.irq_in = 8'h08;
    tick(6);
    chk("mask3_pend", 32'(bus.pend), 32'h00);
    chk("mask3_req", 32'(bus.int_req), 32'd0);
    bus.irq_in = 8'h00;
    write_mask(8'h00);
    tick(2);
    chk("mask3_discard", 32'(bus.pend), 32'h00);
    chk("mask3_discard_req", 32'(bus.int_req), 32'd0);

    // Masking a held bit, then unmasking it
    bus.irq_in = 8'h01;
    sb_q.push_back(3'd0);
    wait_req("m0");
    pulse_ack();
    bus.irq_in = 8'h11;
    tick(4);
    chk("serv_accum_pend", 32'(bus.pend), 32'h10);
    write_mask(8'h10);
    chk("mask4_pend", 32'(bus.pend), 32'h00);
    pulse_eoi();
    tick(3);
    chk("mask4_req", 32'(bus.int_req), 32'd0);
    chk("mask4_busy", 32'(bus.int_busy), 32'd0);
    sb_q.push_back(3'd4);
    write_mask(8'h00);
    chk("unmask4_pend", 32'(bus.pend), 32'h10);
    wait_req("unmask4");
    pulse_ack();
    pulse_eoi();
    bus.irq_in = 8'h00;
    tick(4);

    // Rise on the serviced bit in the ack cycle
    bus.irq_in = 8'h02;
    sb_q.push_back(3'd1);
    wait_req("sc_first");
    bus.irq_in = 8'h00;
    tick(4);
    bus.irq_in = 8'h02;
    tick(2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("setclr_pend", 32'(bus.pend), 32'h02);
    chk("setclr_busy", 32'(bus.int_busy), 32'd1);
    sb_q.push_back(3'd1);
    pulse_eoi();
    wait_req("sc_second");
    pulse_ack();
    chk("sc_second_clr", 32'(bus.pend), 32'h00);
    pulse_eoi();
    bus.irq_in = 8'h00;
    tick(4);

    // Protocol abuse
    pulse_ack();
    chk("ack_idle_req", 32'(bus.int_req), 32'd0);
    chk("ack_idle_busy", 32'(bus.int_busy), 32'd0);
    chk("ack_idle_pend", 32'(bus.pend), 32'h00);
    bus.irq_in = 8'h08;
    sb_q.push_back(3'd3);
    wait_req("abuse");
    pulse_eoi();
    chk("eoi_req_req", 32'(bus.int_req), 32'd1);
    chk("eoi_req_busy", 32'(bus.int_busy), 32'd0);
    chk("eoi_req_vec", 32'(bus.int_vec), 32'd3);
    chk("eoi_req_pend", 32'(bus.pend), 32'h08);
    bus.int_ack = 1'b1;
    bus.int_eoi = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    chk("ackeoi_busy", 32'(bus.int_busy), 32'd1);
    chk("ackeoi_pend", 32'(bus.pend), 32'h00);
    write_mask(8'h80);
    chk("serv_mask_q", 32'(bus.mask_q), 32'h80);

    // Reset during SERV
    rst_n      = 1'b0;
    bus.irq_in = 8'h00;
    tick();
    chk("rstserv_busy", 32'(bus.int_busy), 32'd0);
    chk("rstserv_req", 32'(bus.int_req), 32'd0);
    chk("rstserv_pend", 32'(bus.pend), 32'h00);
    chk("rstserv_vec", 32'(bus.int_vec), 32'd0);
    chk("rstserv_mask", 32'(bus.mask_q), 32'h00);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_req", 32'(bus.int_req), 32'd0);
    chk("post_rst_pend", 32'(bus.pend), 32'h00);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
